// File: rtl/rib_mem_master.sv
// rib_mem_master: bus initiator for the word-only RIB memory responder.
// Turns core byte/half/word loads and stores into word bus transactions. Sub-word stores
// are done as read-modify-write. Loads are lane-extracted and sign/zero-extended.
// Misaligned or reserved-size commands and missing-ack timeouts produce an error response.
//
// Ports:
//   clk, rst           clock, synchronous active-low reset
//   cmd_*_i / cmd_ready_o   command from the core (accepted on valid && ready)
//   rsp_valid_o, rsp_rdata_o, rsp_err_o   one-cycle response
//   mem_req_o, mem_we_o, mem_addr_o, mem_data_o, mem_data_i, mem_ack_i   RIB bus
module rib_mem_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [1:0]  cmd_size_i,
  input  logic        cmd_signed_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic [31:0] mem_data_i,
  input  logic        mem_ack_i
);

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StRd, StRmwRd, StWr, StResp} state_e;

  state_e      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;    // store data; becomes the merged word after RMW read
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        cmd_bad;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;
  logic [31:0] merged;

  assign cmd_bad = (cmd_size_i == 2'd3) ||
                   ((cmd_size_i == 2'd1) && cmd_addr_i[0]) ||
                   ((cmd_size_i == 2'd2) && (cmd_addr_i[1:0] != 2'b00));

  assign rd_byte = mem_data_i[{addr_q[1:0], 3'b000} +: 8];
  assign rd_half = mem_data_i[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    rd_ext = mem_data_i;
    unique case (size_q)
      2'd0:    rd_ext = {{24{signed_q & rd_byte[7]}}, rd_byte};
      2'd1:    rd_ext = {{16{signed_q & rd_half[15]}}, rd_half};
      default: rd_ext = mem_data_i;
    endcase
  end

  always_comb begin
    merged = mem_data_i;
    if (size_q == 2'd0) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
    end else begin
      merged[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          size_d   = cmd_size_i;
          signed_d = cmd_signed_i;
          addr_d   = cmd_addr_i;
          data_d   = cmd_wdata_i;
          rdata_d  = '0;
          err_d    = 1'b0;
          cnt_d    = '0;
          if (cmd_bad) begin
            err_d   = 1'b1;
            state_d = StResp;
          end else if (!cmd_we_i) begin
            state_d = StRd;
          end else if (cmd_size_i == 2'd2) begin
            state_d = StWr;
          end else begin
            state_d = StRmwRd;
          end
        end
      end
      StRd, StRmwRd, StWr: begin
        if (mem_ack_i) begin
          cnt_d = '0;
          if (state_q == StRd) begin
            rdata_d = rd_ext;
            state_d = StResp;
          end else if (state_q == StRmwRd) begin
            data_d  = merged;
            state_d = StWr;
          end else begin
            state_d = StResp;
          end
        end else if (cnt_q == CntLast) begin
          // Abort: rdata stays 0, and an RMW read that times out never writes.
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      size_q   <= '0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs are decoded from registered state, so they are zero whenever idle.
  always_comb begin
    cmd_ready_o = (state_q == StIdle);
    mem_req_o   = (state_q == StRd) || (state_q == StRmwRd) || (state_q == StWr);
    mem_we_o    = (state_q == StWr);
    mem_addr_o  = mem_req_o ? {addr_q[31:2], 2'b00} : '0;
    mem_data_o  = mem_we_o ? data_q : '0;
    rsp_valid_o = (state_q == StResp);
    rsp_rdata_o = rsp_valid_o ? rdata_q : '0;
    rsp_err_o   = rsp_valid_o & err_q;
  end

endmodule

// File: tb/tb_rib_mem_master.sv
// Self-checking bench for rib_mem_master: directed cases plus randomized commands checked
// against an arithmetic reference model and a behavioural RIB responder with variable ack delay.
module tb_rib_mem_master;
  localparam int unsigned TIMEOUT = 16;

  logic        clk, rst;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i, cmd_signed_i;
  logic [1:0]  cmd_size_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic        rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0] mem_addr_o, mem_data_o, mem_data_i;

  rib_mem_master #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_size_i(cmd_size_i), .cmd_signed_i(cmd_signed_i), .cmd_addr_i(cmd_addr_i),
    .cmd_wdata_i(cmd_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .mem_ack_i(mem_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- responder ----------------
  typedef struct {logic we; logic [31:0] addr; logic [31:0] data;} bus_t;
  bus_t        blog[$];
  logic [31:0] bus_mem[16];   // written only by the stimulus thread
  int          ack_delay = 0;
  logic        ack_never = 1'b0;
  logic        no_wr_ack = 1'b0;
  int          req_total = 0;
  int          unstable_total = 0;
  logic        in_phase = 1'b0;
  int          wait_cnt = 0;
  logic [31:0] ph_addr, ph_data;
  logic        ph_we;

  always @(negedge clk) begin
    mem_ack_i  = 1'b0;
    mem_data_i = $urandom;
    if (mem_req_o) begin
      req_total++;
      if (!in_phase) begin
        in_phase = 1'b1;
        wait_cnt = 0;
        ph_addr  = mem_addr_o;
        ph_data  = mem_data_o;
        ph_we    = mem_we_o;
      end else if (ph_addr !== mem_addr_o || ph_data !== mem_data_o || ph_we !== mem_we_o) begin
        unstable_total++;
      end
      if (!ack_never && !(no_wr_ack && mem_we_o) && wait_cnt == ack_delay) begin
        mem_ack_i = 1'b1;
        if (!mem_we_o) mem_data_i = bus_mem[mem_addr_o[5:2]];
        blog.push_back('{we: mem_we_o, addr: mem_addr_o, data: mem_data_o});
        in_phase = 1'b0;
      end else begin
        wait_cnt++;
      end
    end else begin
      in_phase  = 1'b0;
      mem_ack_i = 1'($urandom_range(0, 1));  // stray acks must be ignored
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem[16];

  function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sg, input logic [31:0] a);
    logic [31:0] v;
    if (sz == 2'd2) return w;
    if (sz == 2'd0) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else begin
      v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] w, input logic [31:0] wd,
                                            input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] mask;
    int          sh;
    mask = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
    sh   = 8 * (a % 4);
    return (w & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  // ---------------- command driver ----------------
  task automatic do_cmd(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int nreq, output int nwr, output int nunst,
                        output logic [31:0] wr_addr, output logic [31:0] wr_data);
    int   req0, unst0, log0;
    logic seen;
    @(negedge clk);
    req0  = req_total;
    unst0 = unstable_total;
    log0  = blog.size();
    check("ready_idle", cmd_ready_o, 1);
    cmd_valid_i  = 1'b1;
    cmd_we_i     = we;
    cmd_size_i   = sz;
    cmd_signed_i = sg;
    cmd_addr_i   = a;
    cmd_wdata_i  = wd;
    @(posedge clk);
    #1;
    cmd_valid_i  = 1'b0;
    cmd_we_i     = 1'($urandom);
    cmd_size_i   = 2'($urandom);
    cmd_addr_i   = $urandom;
    cmd_wdata_i  = $urandom;
    lat  = 0;
    rd   = '0;
    er   = 1'b0;
    seen = 1'b0;
    while (!seen && lat < 300) begin
      @(negedge clk);
      lat++;
      if (rsp_valid_o) begin
        seen = 1'b1;
        rd   = rsp_rdata_o;
        er   = rsp_err_o;
      end
    end
    if (!seen) check("rsp_seen", 0, 1);
    @(negedge clk);
    check("rsp_one_cycle", rsp_valid_o, 0);
    nreq    = req_total - req0;
    nunst   = unstable_total - unst0;
    nwr     = 0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = log0; i < blog.size(); i++) begin
      if (blog[i].we) begin
        nwr++;
        wr_addr = blog[i].addr;
        wr_data = blog[i].data;
        bus_mem[blog[i].addr[5:2]] = blog[i].data;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  int          lat, nreq, nwr, nunst, pulses, log0;
  logic [31:0] rd, wa, wdat, a, wd, exp_w;
  logic        er, we, sg, e;
  logic [1:0]  sz;

  initial begin
    rst = 1'b0;
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_size_i = '0; cmd_signed_i = 1'b0;
    cmd_addr_i = '0; cmd_wdata_i = '0;
    for (int i = 0; i < 16; i++) begin
      bus_mem[i] = $urandom;
      ref_mem[i] = bus_mem[i];
    end
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready_o, 1);
    check("rst_ctl", {rsp_valid_o, rsp_err_o, mem_req_o, mem_we_o}, 0);
    check("rst_addr", mem_addr_o, 0);
    check("rst_data", mem_data_o | rsp_rdata_o, 0);
    rst = 1'b1;

    // Word load, immediate ack
    bus_mem[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
    ack_delay = 0;
    log0 = blog.size();
    do_cmd(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd, er, nreq, nwr, nunst, wa, wdat);
    check("wl_lat", lat, 2);
    check("wl_rdata", rd, 32'hDEAD_BEEF);
    check("wl_err", er, 0);
    check("wl_nreq", nreq, 1);
    check("wl_addr", blog[log0].addr, 32'h10);
    check("wl_we", blog[log0].we, 0);

    // Signed / unsigned byte load from lane 3
    bus_mem[4] = 32'h80FF_0000; ref_mem[4] = 32'h80FF_0000;
    do_cmd(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, lat, rd, er, nreq, nwr, nunst, wa, wdat);
    check("lbs_rdata", rd, 32'hFFFF_FF80);
    do_cmd(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, lat, rd, er, nreq, nwr, nunst, wa, wdat);
    check("lbu_rdata", rd, 32'h0000_0080);

    // Byte store via RMW
    bus_mem[8] = 32'h1122_3344; ref_mem[8] = 32'h1122_3344;
    do_cmd(1'b1, 2'd0, 1'b0, 32'h21, 32'hAB, lat, rd, er, nreq, nwr, nunst, wa, wdat);
    check("sb_lat", lat, 3);
    check("sb_err", er, 0);
    check("sb_rdata", rd, 0);
    check("sb_nwr", nwr, 1);
    check("sb_waddr", wa, 32'h20);
    check("sb_wdata", wdat, 32'h1122_AB44);
    ref_mem[8] = 32'h1122_AB44;

    // Misaligned half store: error, no bus activity
    do_cmd(1'b1, 2'd1, 1'b0, 32'h03, 32'hBEEF, lat, rd, er, nreq, nwr, nunst, wa, wdat);
    check("mis_lat", lat, 1);
    check("mis_err", er, 1);
    check("mis_nreq", nreq, 0);

    // Delayed ack
    ack_delay = 5;
    do_cmd(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, lat, rd, er, nreq, nwr, nunst, wa, wdat);
    check("dly_nreq", nreq, 6);
    check("dly_stable", nunst, 0);
    check("dly_lat", lat, 7);
    check("dly_rdata", rd, 32'h1122_AB44);

    // Ack on the last allowed cycle still completes
    ack_delay = TIMEOUT - 1;
    do_cmd(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, lat, rd, er, nreq, nwr, nunst, wa, wdat);
    check("last_err", er, 0);
    check("last_nreq", nreq, TIMEOUT);
    check("last_rdata", rd, 32'h1122_AB44);

    // Timeouts: load and RMW read
    ack_never = 1'b1;
    do_cmd(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd, er, nreq, nwr, nunst, wa, wdat);
    check("to_err", er, 1);
    check("to_nreq", nreq, TIMEOUT);
    check("to_lat", lat, TIMEOUT + 1);
    check("to_rdata", rd, 0);
    do_cmd(1'b1, 2'd1, 1'b0, 32'h22, 32'h5555, lat, rd, er, nreq, nwr, nunst, wa, wdat);
    check("to_rmw_err", er, 1);
    check("to_rmw_nwr", nwr, 0);
    ack_never = 1'b0;

    // Reset during the RMW write phase
    ack_delay = 0;
    no_wr_ack = 1'b1;
    log0 = blog.size();
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_size_i = 2'd0; cmd_addr_i = 32'h31;
    cmd_wdata_i = 32'h77;
    @(posedge clk);
    #1 cmd_valid_i = 1'b0;
    for (int i = 0; i < 10 && !mem_we_o; i++) @(negedge clk);
    check("rrst_in_wr", {mem_req_o, mem_we_o}, 2'b11);
    rst = 1'b0;
    @(negedge clk);
    check("rrst_ready", cmd_ready_o, 1);
    check("rrst_ctl", {rsp_valid_o, rsp_err_o, mem_req_o, mem_we_o}, 0);
    check("rrst_data", mem_addr_o | mem_data_o | rsp_rdata_o, 0);
    rst = 1'b1;
    no_wr_ack = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid_o || mem_req_o) pulses++;
    end
    check("rrst_quiet", pulses, 0);
    nwr = 0;
    for (int i = log0; i < blog.size(); i++) if (blog[i].we) nwr++;
    check("rrst_nwr", nwr, 0);

    // Randomized commands against the reference model
    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom);
      a  = $urandom_range(0, 63);
      wd = $urandom;
      ack_delay = $urandom_range(0, 3);
      e = ref_err(sz, a);
      do_cmd(we, sz, sg, a, wd, lat, rd, er, nreq, nwr, nunst, wa, wdat);
      check("r_err", er, e);
      check("r_stable", nunst, 0);
      if (e) begin
        check("r_err_lat", lat, 1);
        check("r_err_nreq", nreq, 0);
        check("r_err_rdata", rd, 0);
      end else if (!we) begin
        check("r_ld_rdata", rd, ref_load(ref_mem[a / 4], sz, sg, a));
        check("r_ld_lat", lat, 2 + ack_delay);
        check("r_ld_nreq", nreq, 1 + ack_delay);
      end else begin
        exp_w = (sz == 2'd2) ? wd : ref_merge(ref_mem[a / 4], wd, sz, a);
        ref_mem[a / 4] = exp_w;
        check("r_st_rdata", rd, 0);
        check("r_st_nwr", nwr, 1);
        check("r_st_waddr", wa, a & 32'hFFFF_FFFC);
        check("r_st_wdata", wdat, exp_w);
        check("r_st_lat", lat, (sz == 2'd2) ? 2 + ack_delay : 3 + 2 * ack_delay);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
